sdram_rd_prefetch: RTL and testbench
====================================

Name: sdram_rd_prefetch

Overview:
- Sits directly upstream and downstream of the SDRAM read engine in the controller.
- Generates read-burst requests (rd_en, rd_addr, rd_bst_len) over a configured linear address window, wrapping at the end.
- Captures every rd_ack-qualified data word into an internal FIFO.
- Presents buffered data to the user side through a valid/ready stream; single clock domain rd_clk.

Parameters:
- DW, 16, data width; matches the SDRAM data bus.
- AW, 24, SDRAM word address width (bank[23:22], row[21:9], col[8:0]).
- FIFO_AW, 10, FIFO pointer width; depth = 2**FIFO_AW = 1024 words.
- LW, 10, burst length width.

Ports:
- rd_clk  in  1  clock
- rd_rst_n  in  1  asynchronous active-low reset
- init_end  in  1  SDRAM initialisation complete
- cfg_en  in  1  prefetch enable
- cfg_base_addr  in  AW  window start word address
- cfg_end_addr  in  AW  window last word address, inclusive
- cfg_bst_len  in  LW  words per burst, 1..512
- flush  in  1  single-cycle pulse: discard buffer, restart at base
- rd_en  out  1  request to read engine
- rd_addr  out  AW  burst start address
- rd_bst_len  out  LW  burst length, latched per request
- rd_ack  in  1  data beat valid from read engine
- rd_sdram_data  in  DW  beat data
- rd_end  in  1  read engine transaction complete, 1-cycle pulse
- m_data  out  DW  user data, FIFO head
- m_valid  out  1  FIFO not empty
- m_ready  in  1  user accepts head word
- fifo_level  out  FIFO_AW+1  words stored
- ovf  out  1  sticky overflow flag; cleared by flush

Behaviour:
- Reset values:
  - rd_en=0, rd_addr=cfg-independent 0, rd_bst_len=0.
  - FIFO empty: m_valid=0, m_data=0, fifo_level=0.
  - ovf=0, state S_IDLE, next_addr=0, flush_pend=0.
- FSM:
  - S_IDLE -> S_REQ when init_end & cfg_en & !flush_pend & cfg_bst_len!=0 & (2**FIFO_AW - fifo_level - beats_outstanding) >= cfg_bst_len.
    - On this transition: rd_addr<=next_addr, rd_bst_len<=cfg_bst_len, rd_en<=1.
    - On the first S_IDLE cycle after reset or flush, next_addr is loaded from cfg_base_addr.
  - S_REQ: rd_en held at 1 until the first rd_ack, then rd_en<=0 the next cycle -> S_WAIT. A rd_end arriving in S_REQ (engine delivered zero beats) also drops rd_en and goes to S_IDLE.
  - S_WAIT: on rd_end -> S_IDLE. next_addr is computed with a 25-bit sum s=next_addr+rd_bst_len: if s > cfg_end_addr, next_addr<=cfg_base_addr; otherwise next_addr<=s[AW-1:0].
  - Minimum one S_IDLE cycle between requests, so rd_en is low when the engine returns to idle.
- Capture:
  - Every cycle rd_ack=1 pushes rd_sdram_data, in any state.
  - beats_outstanding counts words promised but not yet received.
  - Push when full and no simultaneous pop: word dropped, ovf<=1. Not reachable under the admission rule; verified as protection.
- FIFO is first-word-fall-through:
  - m_data=mem[rptr] while m_valid=1; m_data is 0 when empty.
  - Pop on m_valid & m_ready.
  - Simultaneous push and pop when full: both succeed, level unchanged.
  - Simultaneous push and pop when empty: push only, word visible next cycle.
- Flush:
  - In S_IDLE: pointers, level and ovf clear next cycle; next_addr reloads from base.
  - Mid-burst: flush_pend<=1. Remaining beats of that burst are discarded. At rd_end the flush is applied, then normal operation resumes.
- cfg_en falling mid-burst: the burst completes normally; the FSM then stays in S_IDLE.
- Config changes are sampled only at S_IDLE->S_REQ. Software keeps bursts within one row (col + len <= 512); the block does not check this.
- Reset mid-operation: all state returns to reset values immediately; rd_en drops asynchronously.

Decomposition:
- Shared package sdram_pkg: state encodings, address field slices (BANK/ROW/COL ranges), DW/AW defaults.
- One sub-module, sdram_sync_fifo: FWFT FIFO with push, pop, full, empty, level.

Test Plan:
- Basic: base=0x000100, end=0x0001FF, len=64, m_ready=1; engine model returns 64 beats then rd_end -> requests at 0x100, 0x140, 0x180, 0x1C0, then 0x100 (wrap). Data stream in order, ovf=0.
- Backpressure: m_ready=0, len=256 -> exactly 4 bursts issued, level=1024, rd_en stays 0. One pop is not enough for a new burst; after 256 pops the next request issues.
- Simultaneous push and pop at full (forced by model) -> level holds at 1024, no drop. Extra push with no pop -> ovf=1, level 1024.
- Mid-burst flush at beat 10 of 64 -> remaining 54 beats discarded, level=0 after rd_end. Next request at base, ovf cleared.
- cfg_en=0 at beat 5 -> burst finishes, 64 words stored, no further rd_en.
- Async reset mid-burst (S_WAIT) -> rd_en=0, m_valid=0, level=0 immediately. After release, first request is at base.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller read path: default widths,
// address field positions and the read-prefetch FSM state encoding.
package sdram_pkg;

  localparam int DW_DEF      = 16;
  localparam int AW_DEF      = 24;
  localparam int FIFO_AW_DEF = 10;
  localparam int LW_DEF      = 10;

  // Word address layout: bank[23:22], row[21:9], col[8:0]
  localparam int BANK_MSB = 23;
  localparam int BANK_LSB = 22;
  localparam int ROW_MSB  = 21;
  localparam int ROW_LSB  = 9;
  localparam int COL_MSB  = 8;
  localparam int COL_LSB  = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sdram_sync_fifo.sv
// First-word-fall-through synchronous FIFO: the head word is visible on
// head whenever the FIFO is non-empty; head reads as zero when empty.
module sdram_sync_fifo #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          rd_clk,
  input  logic          rd_rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          drop
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;
  assign head    = empty ? '0 : mem[rptr];

  // NOTE: the storage array has no reset; only pointers and level define
  // validity, and a resettable array would not map onto RAM.
  always_ff @(posedge rd_clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sdram_rd_prefetch.sv
// Read prefetcher: issues bursts over a wrapping address window, buffers
// returned beats in a FWFT FIFO and streams them out via valid/ready.
module sdram_rd_prefetch
  import sdram_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF,
  parameter int LW      = LW_DEF
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic              init_end,
  input  logic              cfg_en,
  input  logic [AW-1:0]     cfg_base_addr,
  input  logic [AW-1:0]     cfg_end_addr,
  input  logic [LW-1:0]     cfg_bst_len,
  input  logic              flush,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  output logic [LW-1:0]     rd_bst_len,
  input  logic              rd_ack,
  input  logic [DW-1:0]     rd_sdram_data,
  input  logic              rd_end,
  output logic [DW-1:0]     m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [FIFO_AW:0]  fifo_level,
  output logic              ovf
);

  localparam int DEPTH = 1 << FIFO_AW;

  rd_state_e     state;
  logic [AW-1:0] next_addr;
  logic          flush_pend;
  logic          load_base;
  logic [LW-1:0] beats_out;

  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_drop;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_clr;
  logic          flush_at_end;
  logic          admit;
  logic [31:0]   need_words;
  logic [AW-1:0] start_addr;
  logic [AW:0]   addr_sum;
  logic [AW-1:0] wrap_addr;

  // Beats of a burst that was flushed mid-flight are thrown away.
  assign fifo_push    = rd_ack & ~flush_pend;
  assign fifo_pop     = m_valid & m_ready;
  assign flush_at_end = (state != S_IDLE) & rd_end & (flush_pend | flush);
  assign fifo_clr     = ((state == S_IDLE) & flush) | flush_at_end;
  assign m_valid      = ~fifo_empty;

  // Room check counts words already promised by an outstanding burst.
  assign need_words = 32'(fifo_level) + 32'(beats_out) + 32'(cfg_bst_len);
  assign admit      = init_end & cfg_en & ~flush_pend & ~flush &
                      (cfg_bst_len != '0) & (need_words <= 32'(DEPTH));

  assign start_addr = load_base ? cfg_base_addr : next_addr;
  assign addr_sum   = {1'b0, next_addr} + (AW+1)'(rd_bst_len);
  assign wrap_addr  = (addr_sum > {1'b0, cfg_end_addr}) ? cfg_base_addr
                                                         : addr_sum[AW-1:0];

  sdram_sync_fifo #(
    .DW (DW),
    .AW (FIFO_AW)
  ) u_fifo (
    .rd_clk    (rd_clk),
    .rd_rst_n  (rd_rst_n),
    .clr       (fifo_clr),
    .push      (fifo_push),
    .push_data (rd_sdram_data),
    .pop       (fifo_pop),
    .head      (m_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      ovf <= 1'b0;
    end else if (fifo_clr) begin
      ovf <= 1'b0;
    end else if (fifo_drop) begin
      ovf <= 1'b1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state      <= S_IDLE;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      rd_bst_len <= '0;
      next_addr  <= '0;
      flush_pend <= 1'b0;
      load_base  <= 1'b1;
      beats_out  <= '0;
    end else begin
      // NOTE: the later nonblocking assignments below override this default
      // decrement, which keeps the outstanding count in one place.
      if (rd_ack && beats_out != '0) beats_out <= beats_out - LW'(1);

      case (state)
        S_IDLE: begin
          if (flush) begin
            load_base <= 1'b1;
          end else if (admit) begin
            rd_en      <= 1'b1;
            rd_addr    <= start_addr;
            rd_bst_len <= cfg_bst_len;
            next_addr  <= start_addr;
            load_base  <= 1'b0;
            beats_out  <= cfg_bst_len;
            state      <= S_REQ;
          end else if (load_base) begin
            next_addr <= cfg_base_addr;
          end
        end

        S_REQ: begin
          if (rd_end) begin
            rd_en     <= 1'b0;
            beats_out <= '0;
            state     <= S_IDLE;
            if (rd_ack) next_addr <= wrap_addr;
          end else if (rd_ack) begin
            rd_en <= 1'b0;
            state <= S_WAIT;
          end
          if (flush && !rd_end) flush_pend <= 1'b1;
        end

        S_WAIT: begin
          if (rd_end) begin
            next_addr <= wrap_addr;
            beats_out <= '0;
            state     <= S_IDLE;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end

        default: begin
          rd_en <= 1'b0;
          state <= S_IDLE;
        end
      endcase

      // A pending or coincident flush is applied as the burst closes.
      if (flush_at_end) begin
        flush_pend <= 1'b0;
        load_base  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_rd_prefetch.sv
// Directed-random bench: a queue-based model of the buffer and the window
// address rule predicts every request, stored word and flag.
module tb_sdram_rd_prefetch;

  logic        rd_clk = 1'b0;
  logic        rd_rst_n;
  logic        init_end;
  logic        cfg_en;
  logic [23:0] cfg_base_addr;
  logic [23:0] cfg_end_addr;
  logic [9:0]  cfg_bst_len;
  logic        flush;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [9:0]  rd_bst_len;
  logic        rd_ack;
  logic [15:0] rd_sdram_data;
  logic        rd_end;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [10:0] fifo_level;
  logic        ovf;

  always #5 rd_clk = ~rd_clk;

  sdram_rd_prefetch dut (
    .rd_clk        (rd_clk),
    .rd_rst_n      (rd_rst_n),
    .init_end      (init_end),
    .cfg_en        (cfg_en),
    .cfg_base_addr (cfg_base_addr),
    .cfg_end_addr  (cfg_end_addr),
    .cfg_bst_len   (cfg_bst_len),
    .flush         (flush),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_bst_len    (rd_bst_len),
    .rd_ack        (rd_ack),
    .rd_sdram_data (rd_sdram_data),
    .rd_end        (rd_end),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .fifo_level    (fifo_level),
    .ovf           (ovf)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [15:0] q[$];
  bit          m_ovf    = 1'b0;
  bit          m_fpend  = 1'b0;
  bit          in_burst = 1'b0;
  logic [23:0] c_base;
  logic [23:0] c_end;
  int          c_len;
  logic [23:0] exp_addr;
  int          l0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] nxt(input logic [23:0] a);
    logic [24:0] s;
    s = {1'b0, a} + 25'(c_len);
    return (s > {1'b0, c_end}) ? c_base : s[23:0];
  endfunction

  task automatic set_cfg(input logic [23:0] b, input logic [23:0] e, input int len);
    c_base = b; c_end = e; c_len = len;
    cfg_base_addr = b; cfg_end_addr = e; cfg_bst_len = 10'(len);
  endtask

  // One clock: drive inputs, advance the model, then compare at the negedge.
  task automatic cycle(input bit ack, input bit endp, input bit fl);
    bit popping;
    bit full_before;
    bit fp_old;
    rd_ack = ack; rd_end = endp; flush = fl;
    rd_sdram_data = 16'($urandom);
    popping = m_ready && (q.size() > 0);
    fp_old  = m_fpend;
    if (fl && !in_burst) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      full_before = (q.size() == 1024);
      if (popping) void'(q.pop_front());
      if (ack && !fp_old) begin
        if (!full_before || popping) q.push_back(rd_sdram_data);
        else m_ovf = 1'b1;
      end
      if (fl) m_fpend = 1'b1;
      if (endp && (fp_old || fl)) begin
        q.delete();
        m_ovf   = 1'b0;
        m_fpend = 1'b0;
      end
    end
    @(negedge rd_clk);
    rd_ack = 1'b0; rd_end = 1'b0; flush = 1'b0;
    check("level", 32'(fifo_level), 32'(q.size()));
    check("m_valid", 32'(m_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("m_data", 32'(m_data), 32'(q[0]));
    else               check("m_data_empty", 32'(m_data), 32'h0);
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic wait_req(input logic [23:0] ea, input int el);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (rd_en === 1'b1) seen = 1'b1;
      else cycle(0, 0, 0);
    end
    check("req_seen", 32'(seen), 32'h1);
    if (seen) begin
      check("rd_addr", 32'(rd_addr), 32'(ea));
      check("rd_bst_len", 32'(rd_bst_len), 32'(el));
      in_burst = 1'b1;
    end
  endtask

  // Engine model: one wait cycle, n beats with random gaps, then rd_end.
  task automatic run_beats(input int n, input int flush_at, input int off_at);
    cycle(0, 0, 0);
    check("rd_en_held", 32'(rd_en), 32'h1);
    for (int i = 1; i <= n; i++) begin
      if (i > 1 && $urandom_range(0, 3) == 0) cycle(0, 0, 0);
      cycle(1, 0, 0);
      if (i == 1) check("rd_en_drop", 32'(rd_en), 32'h0);
      if (i == flush_at) cycle(0, 0, 1);
      if (i == off_at) cfg_en = 1'b0;
    end
    cycle(0, 1, 0);
    in_burst = 1'b0;
  endtask

  task automatic idle_no_req(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 0, 0);
      check("no_req", 32'(rd_en), 32'h0);
    end
  endtask

  initial begin
    rd_rst_n = 1'b0; init_end = 1'b0; cfg_en = 1'b1; flush = 1'b0;
    rd_ack = 1'b0; rd_end = 1'b0; rd_sdram_data = '0; m_ready = 1'b1;
    set_cfg(24'h000100, 24'h0001FF, 64);
    #12;
    check("rst_rd_en", 32'(rd_en), 32'h0);
    check("rst_rd_addr", 32'(rd_addr), 32'h0);
    check("rst_rd_bst_len", 32'(rd_bst_len), 32'h0);
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_m_data", 32'(m_data), 32'h0);
    check("rst_level", 32'(fifo_level), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    idle_no_req(5);
    init_end = 1'b1;

    // Basic window walk with wrap back to base
    exp_addr = c_base;
    for (int k = 0; k < 5; k++) begin
      wait_req(exp_addr, c_len);
      run_beats(c_len, 0, 0);
      exp_addr = nxt(exp_addr);
    end

    // Mid-burst flush at beat 10: rest discarded, restart at base
    wait_req(exp_addr, c_len);
    run_beats(c_len, 10, 0);
    check("flush_level", 32'(fifo_level), 32'h0);
    exp_addr = c_base;
    wait_req(exp_addr, c_len);
    run_beats(c_len, 0, 0);
    exp_addr = nxt(exp_addr);

    // cfg_en dropped at beat 5: burst completes, nothing further
    wait_req(exp_addr, c_len);
    m_ready = 1'b0;
    l0 = q.size();
    run_beats(c_len, 0, 5);
    idle_no_req(30);
    check("cfg_off_level", 32'(fifo_level), 32'(l0 + 64));

    // Backpressure: four 256-word bursts fill the buffer
    set_cfg(24'h000000, 24'h0FFFFF, 256);
    cycle(0, 0, 1);
    cfg_en = 1'b1;
    exp_addr = c_base;
    for (int k = 0; k < 4; k++) begin
      wait_req(exp_addr, c_len);
      run_beats(c_len, 0, 0);
      exp_addr = nxt(exp_addr);
    end
    idle_no_req(20);
    check("full_level", 32'(fifo_level), 32'd1024);
    m_ready = 1'b1; cycle(0, 0, 0); m_ready = 1'b0;
    idle_no_req(10);
    m_ready = 1'b1;
    repeat (254) cycle(0, 0, 0);
    m_ready = 1'b0;
    idle_no_req(10);
    m_ready = 1'b1; cycle(0, 0, 0); m_ready = 1'b0;
    wait_req(exp_addr, c_len);
    run_beats(c_len, 0, 0);
    check("refill_level", 32'(fifo_level), 32'd1024);

    // Push+pop at full holds level; push alone at full overflows
    m_ready = 1'b1;
    cycle(1, 0, 0);
    check("full_pushpop_level", 32'(fifo_level), 32'd1024);
    check("full_pushpop_ovf", 32'(ovf), 32'h0);
    m_ready = 1'b0;
    cycle(1, 0, 0);
    check("ovf_set", 32'(ovf), 32'h1);
    check("ovf_level", 32'(fifo_level), 32'd1024);

    // Idle flush clears ovf, then async reset in the middle of a burst
    set_cfg(24'h000100, 24'h0001FF, 64);
    cycle(0, 0, 1);
    check("ovf_cleared", 32'(ovf), 32'h0);
    m_ready = 1'b1;
    exp_addr = c_base;
    wait_req(exp_addr, c_len);
    cycle(0, 0, 0);
    repeat (20) cycle(1, 0, 0);
    #2 rd_rst_n = 1'b0;
    #1;
    check("async_rd_en", 32'(rd_en), 32'h0);
    check("async_m_valid", 32'(m_valid), 32'h0);
    check("async_level", 32'(fifo_level), 32'h0);
    q.delete(); m_ovf = 1'b0; m_fpend = 1'b0; in_burst = 1'b0;
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    wait_req(c_base, c_len);
    run_beats(c_len, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
